// File: rtl/change_dispenser.sv
// change_dispenser
//   Pays out change greedily from three coin tubes (5, 2 and 1 credit units).
//   A start in IDLE latches the amount. Each SELECT cycle then picks the largest
//   coin that both fits the remaining amount and is still in stock. That coin's
//   strobe is held for PULSE_CYCLES clocks, followed by GAP_CYCLES low clocks.
//   When nothing more can be paid, the block finishes with a one-cycle done
//   pulse, and any unpaid remainder is left on shortfall.
//
// Ports
//   clk, rst               rising-edge clock; asynchronous active-low reset
//   start, amount          one-cycle request plus the amount to pay (IDLE only)
//   refill                 reload every tube to TUBE_MAX (IDLE only)
//   eject1/2/5             coin-release strobes, at most one high at a time
//   busy, done             transaction in flight / one-cycle completion pulse
//   shortfall, short_flag  unpaid remainder of the last transaction, and (!= 0)
//   tube1/2/5              coins left in each tube
module change_dispenser #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int TUBE_MAX     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] amount,
  input  logic       refill,
  output logic       eject1,
  output logic       eject2,
  output logic       eject5,
  output logic       busy,
  output logic       done,
  output logic [7:0] shortfall,
  output logic       short_flag,
  output logic [3:0] tube1,
  output logic [3:0] tube2,
  output logic [3:0] tube5
);

  typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE} state_t;
  typedef enum logic [1:0] {D_NONE, D1, D2, D5} denom_t;

  // The counter is loaded with N-1 on state entry, so the state lasts N clocks.
  localparam logic [7:0] PULSE_LD  = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LD    = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] TUBE_FULL = 4'(TUBE_MAX);

  state_t     state, state_nx;
  denom_t     sel, sel_nx, pick;
  logic [7:0] cnt, cnt_nx;
  logic [7:0] remaining, rem_nx;
  logic [7:0] shortfall_nx;
  logic [7:0] dval;
  logic [3:0] tube1_nx, tube2_nx, tube5_nx;
  logic       eject1_nx, eject2_nx, eject5_nx, busy_nx, done_nx, short_flag_nx;

  function automatic logic [3:0] sat_dec(input logic [3:0] t);
    return (t == 4'd0) ? 4'd0 : t - 4'd1;
  endfunction

  // Greedy choice: the largest coin that fits the remaining amount and is in stock.
  always_comb begin
    pick = D_NONE;
    if      (remaining >= 8'd5 && tube5 != 4'd0) pick = D5;
    else if (remaining >= 8'd2 && tube2 != 4'd0) pick = D2;
    else if (remaining >= 8'd1 && tube1 != 4'd0) pick = D1;
  end

  always_comb begin
    case (sel)
      D5:      dval = 8'd5;
      D2:      dval = 8'd2;
      D1:      dval = 8'd1;
      default: dval = 8'd0;
    endcase
  end

  // State register; every output is registered alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sel        <= D_NONE;
      cnt        <= '0;
      remaining  <= '0;
      shortfall  <= '0;
      short_flag <= 1'b0;
      tube1      <= TUBE_FULL;
      tube2      <= TUBE_FULL;
      tube5      <= TUBE_FULL;
      eject1     <= 1'b0;
      eject2     <= 1'b0;
      eject5     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      cnt        <= cnt_nx;
      remaining  <= rem_nx;
      shortfall  <= shortfall_nx;
      short_flag <= short_flag_nx;
      tube1      <= tube1_nx;
      tube2      <= tube2_nx;
      tube5      <= tube5_nx;
      eject1     <= eject1_nx;
      eject2     <= eject2_nx;
      eject5     <= eject5_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

  // Next state and datapath.
  always_comb begin
    state_nx     = state;
    sel_nx       = sel;
    cnt_nx       = 8'd0;
    rem_nx       = remaining;
    shortfall_nx = shortfall;
    tube1_nx     = tube1;
    tube2_nx     = tube2;
    tube5_nx     = tube5;
    case (state)
      IDLE: begin
        // A refill takes effect on the same edge that accepts a start, so the
        // first SELECT of that transaction already sees full tubes.
        if (refill) begin
          tube1_nx = TUBE_FULL;
          tube2_nx = TUBE_FULL;
          tube5_nx = TUBE_FULL;
        end
        if (start) begin
          state_nx     = SELECT;
          rem_nx       = amount;
          shortfall_nx = 8'd0;
        end
      end
      SELECT: begin
        if (remaining == 8'd0) begin
          state_nx = DONE;
        end else if (pick != D_NONE) begin
          state_nx = EJECT;
          sel_nx   = pick;
          cnt_nx   = PULSE_LD;
        end else begin
          state_nx     = DONE;
          shortfall_nx = remaining;
        end
      end
      EJECT: begin
        if (cnt == 8'd0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LD;
          rem_nx   = remaining - dval;  // dval <= remaining was checked in SELECT
          case (sel)
            D5:      tube5_nx = sat_dec(tube5);
            D2:      tube2_nx = sat_dec(tube2);
            D1:      tube1_nx = sat_dec(tube1);
            default: ;
          endcase
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd0) state_nx = SELECT;
        else             cnt_nx   = cnt - 8'd1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output values for the next cycle, taken from the next state.
  always_comb begin
    eject5_nx     = (state_nx == EJECT) && (sel_nx == D5);
    eject2_nx     = (state_nx == EJECT) && (sel_nx == D2);
    eject1_nx     = (state_nx == EJECT) && (sel_nx == D1);
    busy_nx       = (state_nx != IDLE);
    done_nx       = (state_nx == DONE);
    short_flag_nx = (shortfall_nx != 8'd0);
  end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  localparam int PC = 2;
  localparam int GC = 1;
  localparam int TM = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       refill = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       eject1, eject2, eject5, busy, done, short_flag;
  logic [7:0] shortfall;
  logic [3:0] tube1, tube2, tube5;

  change_dispenser #(.PULSE_CYCLES(PC), .GAP_CYCLES(GC), .TUBE_MAX(TM)) dut (
    .clk(clk), .rst(rst), .start(start), .amount(amount), .refill(refill),
    .eject1(eject1), .eject2(eject2), .eject5(eject5), .busy(busy), .done(done),
    .shortfall(shortfall), .short_flag(short_flag),
    .tube1(tube1), .tube2(tube2), .tube5(tube5)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  // Reference model: coin stock per tube.
  int m1 = TM, m2 = TM, m5 = TM;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one transaction from a negedge. The model pays greedily from its tube
  // counts, then expands the coin list into a per-cycle timeline:
  //   SELECT, then for each coin PC strobe cycles + GC gap cycles + SELECT, then DONE, IDLE.
  // Vector layout: {eject5, eject2, eject1, busy, done}.
  // inject pulses start+refill during the first EJECT and start on the done cycle.
  task automatic txn(input logic [7:0] amt, input bit with_refill, input bit inject);
    logic [4:0] expv[$];
    int coins[$];
    int rem;
    logic [4:0] sv;
    if (with_refill) begin m1 = TM; m2 = TM; m5 = TM; end
    rem = amt;
    while (rem > 0) begin
      if      (rem >= 5 && m5 > 0) begin coins.push_back(5); m5--; rem -= 5; end
      else if (rem >= 2 && m2 > 0) begin coins.push_back(2); m2--; rem -= 2; end
      else if (rem >= 1 && m1 > 0) begin coins.push_back(1); m1--; rem -= 1; end
      else break;
    end
    expv.push_back(5'b00010);
    foreach (coins[k]) begin
      sv = (coins[k] == 5) ? 5'b10010 : (coins[k] == 2) ? 5'b01010 : 5'b00110;
      for (int p = 0; p < PC; p++) expv.push_back(sv);
      for (int g = 0; g < GC; g++) expv.push_back(5'b00010);
      expv.push_back(5'b00010);
    end
    expv.push_back(5'b00011);
    expv.push_back(5'b00000);

    amount = amt; start = 1'b1; refill = with_refill;
    for (int i = 0; i < expv.size(); i++) begin
      @(negedge clk);
      start = 1'b0; refill = 1'b0;
      chk($sformatf("amt%0d_cyc%0d", amt, i + 1), {eject5, eject2, eject1, busy, done}, expv[i]);
      if (i == 0) chk("short_clear", shortfall, 0);
      if (inject && i == 1) begin start = 1'b1; refill = 1'b1; end
      if (inject && i == expv.size() - 2) start = 1'b1;
    end
    chk($sformatf("amt%0d_short", amt), shortfall, rem);
    chk($sformatf("amt%0d_flag", amt), short_flag, rem != 0);
    chk($sformatf("amt%0d_tube1", amt), tube1, m1);
    chk($sformatf("amt%0d_tube2", amt), tube2, m2);
    chk($sformatf("amt%0d_tube5", amt), tube5, m5);
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_strobes", {eject5, eject2, eject1}, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_short", {short_flag, shortfall}, 0);
    chk("rst_tubes", {tube1, tube2, tube5}, {4'd8, 4'd8, 4'd8});

    // Start accepted on the first edge after reset release; greedy 5,2,1.
    @(negedge clk);
    rst = 1'b1;
    txn(8'd8, 1'b0, 1'b0);
    txn(8'd0, 1'b0, 1'b0);

    // Drain tube5, then 7 must be paid 2,2,2,1.
    txn(8'd0, 1'b1, 1'b0);
    repeat (8) txn(8'd5, 1'b0, 1'b0);
    txn(8'd7, 1'b0, 1'b0);

    // Shortfall: tube1=0, tube2=0, tube5=1, then 8 leaves 3 unpaid.
    txn(8'd0, 1'b1, 1'b0);
    repeat (8) txn(8'd1, 1'b0, 1'b0);
    repeat (8) txn(8'd2, 1'b0, 1'b0);
    repeat (7) txn(8'd5, 1'b0, 1'b0);
    txn(8'd8, 1'b0, 1'b0);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    m1 = TM; m2 = TM; m5 = TM;
    @(negedge clk);
    chk("held_short", shortfall, 3);
    chk("held_flag", short_flag, 1);
    chk("refill_tube1", tube1, TM);
    txn(8'd4, 1'b0, 1'b0);

    // Start/refill while busy and start on the done cycle are ignored.
    txn(8'd8, 1'b0, 1'b1);

    // Reset while eject2 is high.
    amount = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_eject2", eject2, 1);
    #1 rst = 1'b0;
    #1;
    chk("async_eject2", eject2, 0);
    chk("async_busy", busy, 0);
    chk("async_tubes", {tube1, tube2, tube5}, {4'd8, 4'd8, 4'd8});
    @(negedge clk);
    rst = 1'b1;
    m1 = TM; m2 = TM; m5 = TM;
    txn(8'd1, 1'b0, 1'b0);

    // Random amounts, sometimes with a refill alongside start.
    repeat (25) begin
      txn(8'($urandom_range(0, 30)), ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
